// File: rtl/wb_interconnect_nx_if.sv
// Wishbone bus bundle for wb_interconnect_nx: one master-facing side and
// flattened slave-facing vectors (slave k occupies slice k).
interface wb_interconnect_nx_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLV_AW     = 12
);
  logic [31:0]              m_wb_dat_i;
  logic [31:0]              m_wb_adr_i;
  logic [3:0]               m_wb_sel_i;
  logic                     m_wb_we_i;
  logic                     m_wb_cyc_i;
  logic                     m_wb_stb_i;
  logic [31:0]              m_wb_dat_o;
  logic                     m_wb_ack_o;
  logic                     m_wb_err_o;

  logic [NUM_SLAVES*32-1:0]     s_wb_dat_i;
  logic [NUM_SLAVES-1:0]        s_wb_ack_i;
  logic [NUM_SLAVES*32-1:0]     s_wb_dat_o;
  logic [NUM_SLAVES*SLV_AW-1:0] s_wb_adr_o;
  logic [NUM_SLAVES*4-1:0]      s_wb_sel_o;
  logic [NUM_SLAVES-1:0]        s_wb_we_o;
  logic [NUM_SLAVES-1:0]        s_wb_cyc_o;
  logic [NUM_SLAVES-1:0]        s_wb_stb_o;

  // Environment side: the bus initiator plus the attached slave devices.
  modport master (
    output m_wb_dat_i, m_wb_adr_i, m_wb_sel_i, m_wb_we_i, m_wb_cyc_i, m_wb_stb_i,
    input  m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
    output s_wb_dat_i, s_wb_ack_i,
    input  s_wb_dat_o, s_wb_adr_o, s_wb_sel_o, s_wb_we_o, s_wb_cyc_o, s_wb_stb_o
  );

  // Interconnect side.
  modport slave (
    input  m_wb_dat_i, m_wb_adr_i, m_wb_sel_i, m_wb_we_i, m_wb_cyc_i, m_wb_stb_i,
    output m_wb_dat_o, m_wb_ack_o, m_wb_err_o,
    input  s_wb_dat_i, s_wb_ack_i,
    output s_wb_dat_o, s_wb_adr_o, s_wb_sel_o, s_wb_we_o, s_wb_cyc_o, s_wb_stb_o
  );
endinterface

// File: rtl/wb_interconnect_nx.sv
// Single-master to N-slave Wishbone interconnect: registered request, address
// decode on a target-id field, per-request ack timeout and one-cycle response.
module wb_interconnect_nx #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SLV_AW     = 12,
  parameter int unsigned TID_LSB    = 12,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wb_interconnect_nx_if.slave  bus,
  output logic                 busy_o
);
  localparam int unsigned TIDW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned HI   = TID_LSB + TIDW;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state;
  logic [31:0]       dat_q;
  logic [31:0]       rdat_q;
  logic [SLV_AW-1:2] adr_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [TIDW-1:0]   tid_q;
  logic [15:0]       cnt_q;
  logic              fail_q;
  logic              ack_q;
  logic              err_q;
  logic [31:0]       mdat_q;

  logic [TIDW-1:0]   tid;
  logic              mapped;
  logic              sel_ack;
  logic [31:0]       sel_dat;
  logic              unused_adr;

  assign unused_adr = ^bus.m_wb_adr_i;

  always_comb begin
    tid     = bus.m_wb_adr_i[HI-1:TID_LSB];
    mapped  = (32'(tid) < NUM_SLAVES) && ((bus.m_wb_adr_i >> HI) == '0);
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (tid_q == TIDW'(k)) begin
        sel_ack = bus.s_wb_ack_i[k];
        sel_dat = bus.s_wb_dat_i[k*32 +: 32];
      end
    end
  end

  // Response pulse is registered in RESP, so it is visible while the FSM is
  // already back in IDLE and able to accept the next request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      dat_q  <= '0;
      rdat_q <= '0;
      adr_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      tid_q  <= '0;
      cnt_q  <= '0;
      fail_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      mdat_q <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      mdat_q <= '0;
      case (state)
        IDLE: begin
          if (bus.m_wb_cyc_i && bus.m_wb_stb_i) begin
            dat_q  <= bus.m_wb_dat_i;
            adr_q  <= bus.m_wb_adr_i[SLV_AW-1:2];
            sel_q  <= bus.m_wb_sel_i;
            we_q   <= bus.m_wb_we_i;
            tid_q  <= tid;
            cnt_q  <= '0;
            rdat_q <= '0;
            fail_q <= !mapped;
            state  <= mapped ? REQ : RESP;
          end
        end
        REQ: begin
          if (!bus.m_wb_cyc_i) begin
            state <= IDLE;
          end else if (sel_ack) begin
            rdat_q <= sel_dat;
            fail_q <= 1'b0;
            state  <= RESP;
          end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            fail_q <= 1'b1;
            state  <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RESP: begin
          ack_q  <= !fail_q;
          err_q  <= fail_q;
          mdat_q <= (fail_q || we_q) ? '0 : rdat_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.s_wb_dat_o = '0;
    bus.s_wb_adr_o = '0;
    bus.s_wb_sel_o = '0;
    bus.s_wb_we_o  = '0;
    bus.s_wb_cyc_o = '0;
    bus.s_wb_stb_o = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (state == REQ && tid_q == TIDW'(k)) begin
        bus.s_wb_dat_o[k*32 +: 32]         = dat_q;
        bus.s_wb_adr_o[k*SLV_AW +: SLV_AW] = {adr_q, 2'b00};
        bus.s_wb_sel_o[k*4 +: 4]           = sel_q;
        bus.s_wb_we_o[k]                   = we_q;
        bus.s_wb_cyc_o[k]                  = 1'b1;
        bus.s_wb_stb_o[k]                  = 1'b1;
      end
    end
  end

  assign bus.m_wb_ack_o = ack_q;
  assign bus.m_wb_err_o = err_q;
  assign bus.m_wb_dat_o = mdat_q;
  assign busy_o         = (state != IDLE);
endmodule

// File: tb/tb_wb_interconnect_nx.sv
// Directed bench for wb_interconnect_nx: a default 4-slave instance and a
// 3-slave instance with an 8-cycle ack timeout.
module tb_wb_interconnect_nx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy_a, busy_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_interconnect_nx_if #(.NUM_SLAVES(4), .SLV_AW(12)) ifa ();
  wb_interconnect_nx_if #(.NUM_SLAVES(3), .SLV_AW(12)) ifb ();

  wb_interconnect_nx #(.NUM_SLAVES(4), .SLV_AW(12), .TID_LSB(12), .TIMEOUT(255)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave), .busy_o(busy_a)
  );
  wb_interconnect_nx #(.NUM_SLAVES(3), .SLV_AW(12), .TID_LSB(12), .TIMEOUT(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.m_wb_cyc_i = 1'b0; ifa.m_wb_stb_i = 1'b0; ifa.m_wb_we_i = 1'b0;
    ifa.m_wb_adr_i = '0;   ifa.m_wb_dat_i = '0;   ifa.m_wb_sel_i = '0;
    ifa.s_wb_ack_i = '0;   ifa.s_wb_dat_i = '0;
  endtask

  task automatic idle_b();
    ifb.m_wb_cyc_i = 1'b0; ifb.m_wb_stb_i = 1'b0; ifb.m_wb_we_i = 1'b0;
    ifb.m_wb_adr_i = '0;   ifb.m_wb_dat_i = '0;   ifb.m_wb_sel_i = '0;
    ifb.s_wb_ack_i = '0;   ifb.s_wb_dat_i = '0;
  endtask

  task automatic req_a(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    ifa.m_wb_adr_i = adr; ifa.m_wb_we_i = we; ifa.m_wb_dat_i = dat;
    ifa.m_wb_sel_i = 4'hF; ifa.m_wb_cyc_i = 1'b1; ifa.m_wb_stb_i = 1'b1;
  endtask

  task automatic req_b(input logic [31:0] adr);
    ifb.m_wb_adr_i = adr; ifb.m_wb_we_i = 1'b0; ifb.m_wb_dat_i = '0;
    ifb.m_wb_sel_i = 4'hF; ifb.m_wb_cyc_i = 1'b1; ifb.m_wb_stb_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_a();
    idle_b();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ack", ifa.m_wb_ack_o, 0);
    check("rst_err", ifa.m_wb_err_o, 0);
    check("rst_dat", ifa.m_wb_dat_o, 0);
    check("rst_busy", busy_a, 0);
    check("rst_cyc", ifa.s_wb_cyc_o, 0);

    // Read 0x1004 from slave1, ack in its first REQ cycle.
    req_a(32'h0000_1004, 1'b0, 32'h0);
    ifa.s_wb_ack_i = 4'b0010;
    ifa.s_wb_dat_i = {32'h0, 32'h0, 32'hA5A5_0001, 32'h0};
    tick();  // edge 0
    check("rd_busy", busy_a, 1);
    check("rd_cyc", ifa.s_wb_cyc_o, 4'b0010);
    check("rd_adr", ifa.s_wb_adr_o[12 +: 12], 12'h004);
    tick();  // edge 1
    check("rd_ack_early", ifa.m_wb_ack_o, 0);
    tick();  // edge 2
    check("rd_ack", ifa.m_wb_ack_o, 1);
    check("rd_err", ifa.m_wb_err_o, 0);
    check("rd_dat", ifa.m_wb_dat_o, 32'hA5A5_0001);
    idle_a();
    tick();
    check("rd_ack_end", ifa.m_wb_ack_o, 0);

    // Write 0x3010 to slave3.
    req_a(32'h0000_3010, 1'b1, 32'h1234_5678);
    tick();
    check("wr_cyc", ifa.s_wb_cyc_o, 4'b1000);
    check("wr_stb", ifa.s_wb_stb_o, 4'b1000);
    check("wr_we", ifa.s_wb_we_o, 4'b1000);
    check("wr_dat", ifa.s_wb_dat_o, {32'h1234_5678, 96'h0});
    check("wr_sel", ifa.s_wb_sel_o, 16'hF000);
    check("wr_adr", ifa.s_wb_adr_o, {12'h010, 36'h0});
    ifa.s_wb_ack_i = 4'b1000;
    tick();
    ifa.s_wb_ack_i = 4'b0000;
    tick();
    check("wr_ack", ifa.m_wb_ack_o, 1);
    check("wr_dat_o", ifa.m_wb_dat_o, 0);
    check("wr_err", ifa.m_wb_err_o, 0);
    idle_a();
    tick();
    check("wr_ack_once", ifa.m_wb_ack_o, 0);

    // Back-to-back reads slave0 then slave2; slave3 acks are noise.
    ifa.s_wb_dat_i = {32'hDEAD_0003, 32'h2222_0002, 32'h0, 32'h1111_0000};
    ifa.s_wb_ack_i = 4'b1101;
    req_a(32'h0000_0008, 1'b0, 32'h0);
    tick(); tick(); tick();
    check("b2b_ack0", ifa.m_wb_ack_o, 1);
    check("b2b_dat0", ifa.m_wb_dat_o, 32'h1111_0000);
    req_a(32'h0000_200C, 1'b0, 32'h0);
    tick();
    check("b2b_accept", ifa.s_wb_cyc_o, 4'b0100);
    check("b2b_adr", ifa.s_wb_adr_o[24 +: 12], 12'h00C);
    tick(); tick();
    check("b2b_ack1", ifa.m_wb_ack_o, 1);
    check("b2b_dat1", ifa.m_wb_dat_o, 32'h2222_0002);
    idle_a();
    tick();

    // Reset in REQ, slave acks afterwards.
    req_a(32'h0000_1000, 1'b0, 32'h0);
    ifa.s_wb_dat_i = {32'h0, 32'h0, 32'h7777_0001, 32'h0};
    tick();
    check("rr_busy_pre", busy_a, 1);
    rst = 1'b1;
    ifa.m_wb_cyc_i = 1'b0; ifa.m_wb_stb_i = 1'b0;
    tick();
    rst = 1'b0;
    ifa.s_wb_ack_i = 4'b0010;
    check("rr_busy", busy_a, 0);
    check("rr_cyc", ifa.s_wb_cyc_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_ack", ifa.m_wb_ack_o, 0);
      check("rr_err", ifa.m_wb_err_o, 0);
      check("rr_dat", ifa.m_wb_dat_o, 0);
      check("rr_busy_post", busy_a, 0);
    end
    idle_a();

    // Unmapped addresses on the 3-slave instance.
    req_b(32'h0000_3000);
    tick();
    check("um1_cyc", ifb.s_wb_cyc_o, 0);
    tick();
    check("um1_err", ifb.m_wb_err_o, 1);
    check("um1_ack", ifb.m_wb_ack_o, 0);
    check("um1_dat", ifb.m_wb_dat_o, 0);
    idle_b();
    tick();
    check("um1_err_end", ifb.m_wb_err_o, 0);
    req_b(32'h0001_0000);
    tick();
    check("um2_cyc", ifb.s_wb_cyc_o, 0);
    tick();
    check("um2_err", ifb.m_wb_err_o, 1);
    check("um2_dat", ifb.m_wb_dat_o, 0);
    idle_b();
    tick();

    // Timeout: slave0 never acks; REQ lasts exactly 8 cycles.
    req_b(32'h0000_0000);
    tick();  // edge 0
    repeat (7) tick();
    check("to_stb_held", ifb.s_wb_stb_o, 3'b001);
    check("to_err_early", ifb.m_wb_err_o, 0);
    tick();  // edge 8
    check("to_stb_drop", ifb.s_wb_stb_o, 0);
    tick();
    check("to_err", ifb.m_wb_err_o, 1);
    check("to_ack", ifb.m_wb_ack_o, 0);
    idle_b();
    tick();

    // Ack on the 8th REQ cycle wins over the timeout.
    req_b(32'h0000_0000);
    tick();
    repeat (7) tick();
    ifb.s_wb_ack_i = 3'b001;
    ifb.s_wb_dat_i = {32'h0, 32'h0, 32'hBEEF_0008};
    tick();
    ifb.s_wb_ack_i = '0;
    tick();
    check("ta_ack", ifb.m_wb_ack_o, 1);
    check("ta_err", ifb.m_wb_err_o, 0);
    check("ta_dat", ifb.m_wb_dat_o, 32'hBEEF_0008);
    idle_b();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
